// File: rtl/uart_cmd_deframer_pkg.sv
// Shared types and constants for the UART command deframer: FSM state
// encoding, error cause codes and default frame parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_A   = 3'd1,
        ST_GET_B   = 3'd2,
        ST_GET_OP  = 3'd3,
        ST_GET_CHK = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] DEF_HEADER       = 8'hAA;
    localparam int         DEF_TIMEOUT_CLKS = 17360;

    // The FSM raises at most one strobe per cycle; the priority only matters
    // if that ever changes.
    function automatic logic [1:0] err_encode(input logic chk, input logic tmo,
                                              input logic ovr);
        logic [1:0] code;
        code = ERR_NONE;
        if (ovr)      code = ERR_OVERRUN;
        else if (tmo) code = ERR_TIMEOUT;
        else if (chk) code = ERR_CHK;
        return code;
    endfunction

endpackage

// File: rtl/uart_cmd_deframer_fsm.sv
// Frame sequencing FSM: holds the state register and decodes the per-cycle
// datapath controls and error strobes; the state is exported for observation.
module uart_cmd_deframer_fsm
    import uart_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   rx_valid,
    input  logic   hdr_match,
    input  logic   chk_ok,
    input  logic   cnt_expired,
    input  logic   cmd_ready,
    output state_t state,
    output state_t state_next,
    output logic   load_a,
    output logic   load_b,
    output logic   load_op,
    output logic   acc_clr,
    output logic   acc_load,
    output logic   cnt_clr,
    output logic   set_valid,
    output logic   clr_valid,
    output logic   err_chk,
    output logic   err_tmo,
    output logic   err_ovr
);

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        acc_clr    = 1'b0;
        acc_load   = 1'b0;
        cnt_clr    = 1'b0;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;
        err_chk    = 1'b0;
        err_tmo    = 1'b0;
        err_ovr    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Non-header bytes fall through silently.
                if (rx_valid && hdr_match) begin
                    acc_clr    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_GET_A;
                end
            end
            ST_GET_A: begin
                if (rx_valid) begin
                    load_a     = 1'b1;
                    acc_load   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_GET_B;
                end else if (cnt_expired) begin
                    err_tmo    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GET_B: begin
                if (rx_valid) begin
                    load_b     = 1'b1;
                    acc_load   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_GET_OP;
                end else if (cnt_expired) begin
                    err_tmo    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GET_OP: begin
                if (rx_valid) begin
                    load_op    = 1'b1;
                    acc_load   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_GET_CHK;
                end else if (cnt_expired) begin
                    err_tmo    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GET_CHK: begin
                if (rx_valid) begin
                    cnt_clr = 1'b1;
                    if (chk_ok) begin
                        set_valid  = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        err_chk    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (cnt_expired) begin
                    err_tmo    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A byte arriving here is lost, even on the transfer cycle.
                if (rx_valid) err_ovr = 1'b1;
                if (cmd_ready) begin
                    clr_valid  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

endmodule

// File: rtl/uart_cmd_deframer.sv
// Assembles 5-byte UART command frames (header, A, B, opcode, checksum) and
// hands validated commands to the ALU; reports checksum, timeout and overrun.
module uart_cmd_deframer
    import uart_pkg::*;
#(
    parameter int         DATA_W       = 8,
    parameter int         OP_W         = 4,
    parameter logic [7:0] HEADER       = DEF_HEADER,
    parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] cmd_a,
    output logic [DATA_W-1:0] cmd_b,
    output logic [OP_W-1:0]   cmd_op,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    // Handshake: cmd_valid rises one clock after an accepted checksum byte and
    // stays high with cmd_a/cmd_b/cmd_op frozen until a clock edge sees
    // cmd_valid && cmd_ready; cmd_ready while cmd_valid is low has no effect.

    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    state_t           state;
    state_t           state_next;
    logic             load_a;
    logic             load_b;
    logic             load_op;
    logic             acc_clr;
    logic             acc_load;
    logic             cnt_clr;
    logic             set_valid;
    logic             clr_valid;
    logic             err_chk;
    logic             err_tmo;
    logic             err_ovr;

    logic [7:0]       acc;
    logic [7:0]       op_byte;
    logic [CNT_W-1:0] cnt;
    logic             cnt_run;
    logic             hdr_match;
    logic             chk_ok;
    logic             cnt_expired;

    assign hdr_match   = (rx_data == HEADER);
    // The opcode byte must also have its unused upper bits clear.
    assign chk_ok      = (rx_data == acc) && ((op_byte >> OP_W) == 8'd0);
    assign cnt_expired = (cnt == CNT_W'(TIMEOUT_CLKS - 1));
    assign cnt_run     = (state == ST_GET_A) || (state == ST_GET_B) ||
                         (state == ST_GET_OP) || (state == ST_GET_CHK);

    uart_cmd_deframer_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .hdr_match  (hdr_match),
        .chk_ok     (chk_ok),
        .cnt_expired(cnt_expired),
        .cmd_ready  (cmd_ready),
        .state      (state),
        .state_next (state_next),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_op    (load_op),
        .acc_clr    (acc_clr),
        .acc_load   (acc_load),
        .cnt_clr    (cnt_clr),
        .set_valid  (set_valid),
        .clr_valid  (clr_valid),
        .err_chk    (err_chk),
        .err_tmo    (err_tmo),
        .err_ovr    (err_ovr)
    );

    // Inter-byte gap counter; parked at zero outside the byte-collecting states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (cnt_clr || !cnt_run) cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= 8'd0;
            cmd_a   <= '0;
            cmd_b   <= '0;
            op_byte <= 8'd0;
        end else begin
            if (acc_clr)       acc <= HEADER;
            else if (acc_load) acc <= acc ^ rx_data;
            if (load_a)  cmd_a   <= rx_data[DATA_W-1:0];
            if (load_b)  cmd_b   <= rx_data[DATA_W-1:0];
            if (load_op) op_byte <= rx_data;
        end
    end

    assign cmd_op = op_byte[OP_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
        end else begin
            if (set_valid)      cmd_valid <= 1'b1;
            else if (clr_valid) cmd_valid <= 1'b0;
            frame_err <= err_chk | err_tmo | err_ovr;
            err_code  <= err_encode(err_chk, err_tmo, err_ovr);
            busy      <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed bench for uart_cmd_deframer: a byte table for whole frames plus
// hand-written sequences for timeout, backpressure/overrun and reset.
module tb_uart_cmd_deframer;

    localparam int TMO = 50;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_op;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int xfers    = 0;
    int err_seen = 0;

    uart_cmd_deframer #(
        .DATA_W      (8),
        .OP_W        (4),
        .HEADER      (8'hAA),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_op   (cmd_op),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .frame_err(frame_err),
        .err_code (err_code),
        .busy     (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and error-pulse monitors
    always @(posedge clk) if (cmd_valid && cmd_ready) xfers++;
    always @(negedge clk) if (frame_err) err_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] b;
        logic       exp_valid;
        logic       exp_err;
        logic [1:0] exp_code;
        logic       exp_busy;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [3:0] exp_op;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic v, input logic e,
                       input logic [1:0] c, input logic bz, input logic [7:0] a,
                       input logic [7:0] bb, input logic [3:0] op);
        vec_t r;
        r.b = b; r.exp_valid = v; r.exp_err = e; r.exp_code = c; r.exp_busy = bz;
        r.exp_a = a; r.exp_b = bb; r.exp_op = op;
        vecs.push_back(r);
    endtask

    // Body bytes of a frame that the deframer should be collecting.
    task automatic add_body(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        add(8'hAA, 0, 0, 2'd0, 1, 8'h00, 8'h00, 4'h0);
        add(a,     0, 0, 2'd0, 1, 8'h00, 8'h00, 4'h0);
        add(b,     0, 0, 2'd0, 1, 8'h00, 8'h00, 4'h0);
        add(op,    0, 0, 2'd0, 1, 8'h00, 8'h00, 4'h0);
    endtask

    // Driver: one-cycle rx_valid strobe; returns 1 time unit after the
    // sampling edge so outputs can be inspected.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] op);
        check({tag, "_a"},  cmd_a,  a);
        check({tag, "_b"},  cmd_b,  b);
        check({tag, "_op"}, cmd_op, op);
    endtask

    initial begin
        int err_cyc;
        int xf0;
        int es0;
        logic [1:0] code_at;
        logic busy_at;
        logic dbl;
        logic prev;

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b0;
        idle(3);
        check("rst_valid", cmd_valid, 0);
        check("rst_err",   frame_err, 0);
        check("rst_code",  err_code,  0);
        check("rst_busy",  busy,      0);
        check_cmd("rst", 8'h00, 8'h00, 4'h0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        // ---- table-driven frames (cmd_ready held high) ----
        add_body(8'h05, 8'h03, 8'h02);
        add(8'hAE, 1, 0, 2'd0, 1, 8'h05, 8'h03, 4'h2);
        add_body(8'h05, 8'h03, 8'h02);
        add(8'hAF, 0, 1, 2'd1, 0, 8'h00, 8'h00, 4'h0);
        add_body(8'h05, 8'h03, 8'h02);
        add(8'hAE, 1, 0, 2'd0, 1, 8'h05, 8'h03, 4'h2);
        add(8'h00, 0, 0, 2'd0, 0, 8'h00, 8'h00, 4'h0);
        add(8'hFF, 0, 0, 2'd0, 0, 8'h00, 8'h00, 4'h0);
        add(8'h55, 0, 0, 2'd0, 0, 8'h00, 8'h00, 4'h0);
        add_body(8'h01, 8'h01, 8'h0F);
        add(8'hA5, 1, 0, 2'd0, 1, 8'h01, 8'h01, 4'hF);
        add_body(8'h01, 8'h02, 8'h13);
        add(8'hBA, 0, 1, 2'd1, 0, 8'h00, 8'h00, 4'h0);
        add_body(8'hAA, 8'hAA, 8'h00);
        add(8'hAA, 1, 0, 2'd0, 1, 8'hAA, 8'hAA, 4'h0);

        cmd_ready = 1'b1;
        foreach (vecs[i]) begin
            send_byte(vecs[i].b);
            check($sformatf("v%0d_valid", i), cmd_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_err",   i), frame_err, vecs[i].exp_err);
            check($sformatf("v%0d_code",  i), err_code,  vecs[i].exp_code);
            check($sformatf("v%0d_busy",  i), busy,      vecs[i].exp_busy);
            if (vecs[i].exp_valid)
                check_cmd($sformatf("v%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op);
            idle(1);
        end
        check("tbl_idle_busy", busy, 0);
        check("tbl_xfers", xfers, 4);

        // ---- timeout: error exactly TMO clocks after the last strobe ----
        send_byte(8'hAA);
        send_byte(8'h05);
        err_cyc = -1; code_at = 2'd0; busy_at = 1'b1; dbl = 1'b0; prev = 1'b0;
        for (int k = 1; k <= TMO + 10; k++) begin
            @(posedge clk); #1;
            if (frame_err && err_cyc < 0) begin
                err_cyc = k; code_at = err_code; busy_at = busy;
            end
            if (frame_err && prev) dbl = 1'b1;
            prev = frame_err;
        end
        check("tmo_cycle", err_cyc, TMO);
        check("tmo_code",  code_at, 2);
        check("tmo_busy",  busy_at, 0);
        check("tmo_single_pulse", dbl, 0);
        check("tmo_idle_busy", busy, 0);

        // ---- byte in the last allowed cycle wins over the timeout ----
        send_byte(8'hAA);
        send_byte(8'h05);
        es0 = err_seen;
        idle(TMO - 1);
        send_byte(8'h03);
        check("win_err",  frame_err, 0);
        check("win_busy", busy, 1);
        check("win_no_pulse", err_seen, es0);
        send_byte(8'h02);
        send_byte(8'hAE);
        check("win_valid", cmd_valid, 1);
        check_cmd("win", 8'h05, 8'h03, 4'h2);
        idle(1);
        check("win_xfers", xfers, 5);

        // ---- backpressure and overrun ----
        cmd_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h03); send_byte(8'h02);
        send_byte(8'hAE);
        check("bp_valid0", cmd_valid, 1);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            check($sformatf("bp_hold%0d_valid", k), cmd_valid, 1);
            check_cmd($sformatf("bp_hold%0d", k), 8'h05, 8'h03, 4'h2);
        end
        send_byte(8'h11);
        check("ovr_err",   frame_err, 1);
        check("ovr_code",  err_code,  3);
        check("ovr_valid", cmd_valid, 1);
        check_cmd("ovr", 8'h05, 8'h03, 4'h2);
        idle(1);
        check("ovr_err_clear", frame_err, 0);
        check("ovr_code_clear", err_code, 0);
        xf0 = xfers;
        @(negedge clk); cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        check("bp_xfer_valid", cmd_valid, 0);
        check("bp_xfer_busy",  busy, 0);
        idle(3);
        check("bp_after_valid", cmd_valid, 0);
        check("bp_single_xfer", xfers - xf0, 1);

        // ---- asynchronous reset while holding a command ----
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h03); send_byte(8'h02);
        send_byte(8'hAE);
        check("hrst_pre_valid", cmd_valid, 1);
        @(negedge clk); rst = 1'b1;
        #1;
        check("hrst_async_valid", cmd_valid, 0);
        check("hrst_async_busy",  busy, 0);
        @(negedge clk); rst = 1'b0;

        // ---- reset mid-frame: trailing bytes have no header ----
        send_byte(8'hAA);
        send_byte(8'h05);
        check("mrst_pre_busy", busy, 1);
        @(negedge clk); rst = 1'b1;
        #1;
        check("mrst_valid", cmd_valid, 0);
        check("mrst_err",   frame_err, 0);
        check("mrst_code",  err_code,  0);
        check("mrst_busy",  busy, 0);
        check_cmd("mrst", 8'h00, 8'h00, 4'h0);
        @(negedge clk); rst = 1'b0;
        es0 = err_seen;
        send_byte(8'h03);
        check("mrst_b0_busy", busy, 0);
        send_byte(8'h02);
        check("mrst_b1_busy", busy, 0);
        send_byte(8'hAE);
        check("mrst_b2_busy", busy, 0);
        idle(2);
        check("mrst_no_valid", cmd_valid, 0);
        check("mrst_no_err", err_seen, es0);
        check("total_xfers", xfers, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_deframer.md
Name: uart_cmd_deframer

Overview:
Sits directly downstream of the UART receiver (RX FSM + datapath) and consumes its received-byte stream. It assembles a fixed 5-byte command frame: header, operand A, operand B, opcode, checksum. It validates the frame and presents the decoded operands and opcode to the ALU through a valid/ready handshake. It also reports framing, checksum, timeout and overrun errors.

Parameters:
- DATA_W, 8, width of operands A/B (one UART byte each).
- OP_W, 4, width of ALU opcode taken from the low bits of the opcode byte.
- HEADER, 8'hAA, frame start byte.
- TIMEOUT_CLKS, 17360, max clocks allowed between consecutive bytes inside a frame (4 byte-times at 434 clks/bit).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe: a new byte is on rx_data (driven by the receiver's data_valid).
- cmd_a  out  DATA_W  operand A; stable while cmd_valid=1.
- cmd_b  out  DATA_W  operand B; stable while cmd_valid=1.
- cmd_op  out  OP_W  ALU opcode; stable while cmd_valid=1.
- cmd_valid  out  1  command available to the ALU.
- cmd_ready  in  1  ALU accepts the command; a transfer occurs when cmd_valid && cmd_ready.
- frame_err  out  1  one-cycle pulse on any error.
- err_code  out  2  cause, valid with frame_err: 1 = checksum/opcode, 2 = timeout, 3 = overrun; 0 otherwise.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cmd_a/cmd_b/cmd_op = 0.
  - cmd_valid=0, frame_err=0, err_code=0, busy=0.
  - Timeout counter and checksum accumulator = 0.
- States: IDLE, GET_A, GET_B, GET_OP, GET_CHK, HOLD.
- IDLE:
  - rx_valid && rx_data==HEADER -> GET_A; checksum acc := HEADER; timeout counter := 0.
  - Any other byte is silently discarded, with no error.
- GET_A / GET_B / GET_OP:
  - On rx_valid, capture the byte into the A / B / op register; acc ^= byte; advance to the next state; counter := 0.
- GET_CHK, on rx_valid:
  - Pass: byte == acc AND op byte[7:OP_W]==0 -> HOLD; cmd_valid=1 starting the next cycle. Total latency is 1 clk after the checksum strobe.
  - Fail: frame_err=1 and err_code=1 for 1 cycle -> IDLE; no command is issued.
- Timeout (GET_A..GET_CHK only):
  - The counter increments every clock without rx_valid.
  - When the counter reaches TIMEOUT_CLKS-1 with no rx_valid: frame_err pulse, err_code=2 -> IDLE.
  - rx_valid in that same cycle wins: the byte is processed and the counter resets.
- HOLD:
  - cmd_valid=1; cmd_* held constant.
  - cmd_ready=1 -> transfer; cmd_valid=0 on the next cycle -> IDLE.
  - rx_valid while in HOLD, including the transfer cycle: byte dropped; frame_err pulse with err_code=3.
  - The timeout counter is idle in HOLD; there is no timeout while waiting on the ALU.
- cmd_ready while cmd_valid=0 is ignored.
- A HEADER byte received mid-frame is treated as data; there is no resynchronisation except via checksum failure or timeout.
- frame_err is never high for 2 consecutive cycles from a single event.
- rst asserted mid-frame or in HOLD:
  - Immediate return to IDLE; any partial frame is lost.
  - cmd_valid drops asynchronously.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package uart_pkg:
  - State enum typedef.
  - err_code localparams: ERR_NONE, ERR_CHK, ERR_TIMEOUT, ERR_OVERRUN.
  - Default HEADER and TIMEOUT_CLKS constants.
- Split FSM and datapath, matching the receiver's style:
  - uart_cmd_deframer_fsm (combinational next-state/control: load_a/b/op, acc_clr, cnt_clr, set_valid, err strobes).
  - Top level holds the registers, counter and accumulator.

Test Plan:
- Good frame: bytes AA,05,03,02,AE with cmd_ready=1 -> cmd_valid high 1 cycle after the AE strobe, with cmd_a=05, cmd_b=03, cmd_op=2; no frame_err; state IDLE afterwards.
- Bad checksum: AA,05,03,02,AF -> frame_err pulse, err_code=1, cmd_valid stays 0; a following good frame is accepted.
- Timeout: AA,05, then no bytes for TIMEOUT_CLKS clocks (use TIMEOUT_CLKS=50) -> frame_err pulse with err_code=2 exactly 50 clocks after the 05 strobe; busy=0.
- Backpressure/overrun: good frame with cmd_ready=0 for 20 cycles -> cmd_valid held with stable outputs. A byte 11 sent during the hold -> err_code=3 pulse, and cmd_a/b/op unchanged. cmd_ready=1 -> single transfer.
- Garbage then frame: 00,FF,55,AA,01,01,0F,A5 -> no errors on the garbage bytes; command A=01, B=01, op=F.
- Reset mid-frame: AA,05, then rst pulse -> all outputs 0. Bytes 03,02,AE afterwards are ignored (no header) and no cmd_valid results.
